// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
// Flow-mode codes, FSM states and the increment helper.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        BJ_SEQ = 3'b000,
        BJ_J   = 3'b001,
        BJ_BEQ = 3'b010,
        BJ_BNE = 3'b011,
        BJ_BLT = 3'b100,
        BJ_BGE = 3'b101,
        BJ_JR  = 3'b110,
        BJ_RSV = 3'b111
    } bj_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_t;

    localparam int unsigned DEF_SHIFT = 2;

    function automatic int unsigned inc_of(input int unsigned shift);
        return 32'd1 << shift;
    endfunction

endpackage

// File: rtl/pc_sequencer_target_gen.sv
// Sequential successor and branch-target adders.
// Purely combinational; both sums wrap at 2^ADDR_W.
module pc_target_gen
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 8,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] target
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(inc_of(SHIFT));

    logic [ADDR_W-1:0] off_x;

    assign off_x   = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign pc_plus = pc + INC;
    assign target  = pc_plus + (off_x << SHIFT);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, flow decode, fetch handshake,
// misaligned-target trap and saturating retired counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                OFF_W    = 8,
    parameter int                SHIFT    = DEF_SHIFT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [2:0]        bjselect,
    input  logic              zero,
    input  logic              neg,
    input  logic [OFF_W-1:0]  offset,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken,
    output logic              flush,
    output logic              trap,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [ADDR_W-1:0] INC  = ADDR_W'(inc_of(SHIFT));
    localparam logic [ADDR_W-1:0] MASK = INC - ADDR_W'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_plus, target, pc_d;
    logic [CNT_W-1:0]  ret_d;
    logic              flush_d, trap_d, is_jr, advance, misaligned;

    pc_target_gen #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W),
        .SHIFT  (SHIFT)
    ) u_tgen (
        .pc      (pc),
        .offset  (offset),
        .pc_plus (pc_plus),
        .target  (target)
    );

    always_comb begin
        taken = 1'b0;
        is_jr = 1'b0;
        case (bj_t'(bjselect))
            BJ_J:    taken = 1'b1;
            BJ_BEQ:  taken = zero;
            BJ_BNE:  taken = !zero;
            BJ_BLT:  taken = neg;
            BJ_BGE:  taken = !neg;
            BJ_JR: begin
                taken = 1'b1;
                is_jr = 1'b1;
            end
            default: taken = 1'b0;
        endcase
    end

    assign pc_next    = is_jr ? reg_target : (taken ? target : pc_plus);
    assign misaligned = |(pc_next & MASK);
    assign advance    = imem_ack && !stall;

    always_comb begin
        state_n  = state;
        pc_d     = pc;
        ret_d    = retired;
        flush_d  = 1'b0;
        trap_d   = trap;
        imem_req = 1'b0;
        unique case (state)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN: begin
                imem_req = 1'b1;
                if (advance && misaligned) begin
                    state_n = ST_TRAP;
                    trap_d  = 1'b1;
                end else if (advance) begin
                    pc_d    = pc_next;
                    flush_d = taken;
                    // saturate rather than wrap the retired count
                    ret_d   = (&retired) ? retired
                                         : retired + CNT_W'(1);
                end
            end
            ST_TRAP: trap_d = 1'b1;
            default: state_n = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_BOOT;
            pc      <= RESET_PC;
            retired <= '0;
            flush   <= 1'b0;
            trap    <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_d;
            retired <= ret_d;
            flush   <= flush_d;
            trap    <= trap_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
// Two instances: defaults, and wrap/saturate variant.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic        boot;
        logic        trp;
        logic        flush;
        int unsigned ret;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        ack_a = 1'b1;
    logic        ack_b = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  bjselect = 3'b000;
    logic        zero = 1'b0;
    logic        neg = 1'b0;
    logic [7:0]  offset = 8'h00;
    logic [31:0] reg_target = 32'h0;

    logic        req_a, flush_a, trap_a, taken_a;
    logic [31:0] pc_a, pcn_a;
    logic [15:0] ret_a;
    logic        req_b, flush_b, trap_b, taken_b;
    logic [31:0] pc_b, pcn_b;
    logic [1:0]  ret_b;

    int nvec = 0;
    int nerr = 0;

    mstate_t m_a, m_b;

    always #5 clk = ~clk;

    pc_sequencer dut_a (
        .clk        (clk),
        .reset_n    (rst_a),
        .stall      (stall),
        .bjselect   (bjselect),
        .zero       (zero),
        .neg        (neg),
        .offset     (offset),
        .reg_target (reg_target),
        .imem_ack   (ack_a),
        .imem_req   (req_a),
        .pc         (pc_a),
        .pc_next    (pcn_a),
        .taken      (taken_a),
        .flush      (flush_a),
        .trap       (trap_a),
        .retired    (ret_a)
    );

    pc_sequencer #(
        .RESET_PC (32'hFFFF_FFFC),
        .CNT_W    (2)
    ) dut_b (
        .clk        (clk),
        .reset_n    (rst_b),
        .stall      (stall),
        .bjselect   (bjselect),
        .zero       (zero),
        .neg        (neg),
        .offset     (offset),
        .reg_target (reg_target),
        .imem_ack   (ack_b),
        .imem_req   (req_b),
        .pc         (pc_b),
        .pc_next    (pcn_b),
        .taken      (taken_b),
        .flush      (flush_b),
        .trap       (trap_b),
        .retired    (ret_b)
    );

    function automatic mstate_t mreset(input int i);
        mstate_t s;
        s.pc    = (i == 1) ? 32'hFFFF_FFFC : 32'h0;
        s.boot  = 1'b1;
        s.trp   = 1'b0;
        s.flush = 1'b0;
        s.ret   = 0;
        return s;
    endfunction

    function automatic logic exp_taken();
        case (bjselect)
            3'd1:    return 1'b1;
            3'd2:    return zero;
            3'd3:    return !zero;
            3'd4:    return neg;
            3'd5:    return !neg;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_next(input logic [31:0] p);
        logic [31:0] plus;
        int          off;
        plus = p + 32'd4;
        off  = $signed(offset);
        if (bjselect == 3'd6) return reg_target;
        if (exp_taken()) return plus + 32'(off * 4);
        return plus;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int i, input logic ack);
        mstate_t     n;
        logic [31:0] nx;
        int unsigned cmax;
        n       = s;
        n.flush = 1'b0;
        cmax    = (i == 1) ? 3 : 65535;
        if (s.boot) begin
            n.boot = 1'b0;
        end else if (!s.trp && ack && !stall) begin
            nx = exp_next(s.pc);
            if (nx % 4 != 0) begin
                n.trp = 1'b1;
            end else begin
                n.pc    = nx;
                n.flush = exp_taken();
                n.ret   = (s.ret < cmax) ? s.ret + 1 : s.ret;
            end
        end
        return n;
    endfunction

    initial begin
        m_a = mreset(0);
        m_b = mreset(1);
    end

    always @(posedge clk or negedge rst_a)
        m_a = rst_a ? mstep(m_a, 0, ack_a) : mreset(0);

    always @(posedge clk or negedge rst_b)
        m_b = rst_b ? mstep(m_b, 1, ack_b) : mreset(1);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input mstate_t m, input logic rst,
                           input logic [31:0] pc, input logic req, input logic fl,
                           input logic tr, input logic [31:0] ret,
                           input logic [31:0] pcn, input logic tk);
        chk({tag, ".pc"}, 64'(pc), 64'(m.pc));
        chk({tag, ".req"}, 64'(req), 64'(rst && !m.boot && !m.trp));
        chk({tag, ".flush"}, 64'(fl), 64'(m.flush));
        chk({tag, ".trap"}, 64'(tr), 64'(m.trp));
        chk({tag, ".retired"}, 64'(ret), 64'(m.ret));
        chk({tag, ".pc_next"}, 64'(pcn), 64'(exp_next(m.pc)));
        chk({tag, ".taken"}, 64'(tk), 64'(exp_taken()));
    endtask

    always @(negedge clk) begin
        cmp_all("A", m_a, rst_a, pc_a, req_a, flush_a, trap_a, 32'(ret_a), pcn_a, taken_a);
        cmp_all("B", m_b, rst_b, pc_b, req_b, flush_b, trap_b, 32'(ret_b), pcn_b, taken_b);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(2);
        rst_a = 1'b1;
        #1;
        chk("t1.reset_pc", 64'(pc_a), 64'h0);
        chk("t1.reset_req", 64'(req_a), 64'h0);
        chk("t1.reset_ret", 64'(ret_a), 64'h0);
        cyc(1);
        chk("t1.boot_pc", 64'(pc_a), 64'h0);
        chk("t1.run_req", 64'(req_a), 64'h1);
        cyc(1);
        chk("t1.pc4", 64'(pc_a), 64'h4);
        cyc(1);
        chk("t1.pc8", 64'(pc_a), 64'h8);
        chk("t1.ret2", 64'(ret_a), 64'h2);

        cyc(2);
        chk("t2.pc10", 64'(pc_a), 64'h10);
        bjselect = 3'b010; zero = 1'b1; offset = 8'hFE;
        cyc(1);
        chk("t2.beq_pc", 64'(pc_a), 64'h0C);
        chk("t2.beq_flush", 64'(flush_a), 64'h1);
        bjselect = 3'b000;
        cyc(1);
        chk("t2.back_pc", 64'(pc_a), 64'h10);
        bjselect = 3'b010; zero = 1'b0;
        cyc(1);
        chk("t2.nt_pc", 64'(pc_a), 64'h14);
        chk("t2.nt_flush", 64'(flush_a), 64'h0);

        bjselect = 3'b110; reg_target = 32'h0;
        cyc(1);
        chk("t3.jr0", 64'(pc_a), 64'h0);
        bjselect = 3'b100; neg = 1'b1; offset = 8'h03;
        cyc(1);
        chk("t3.blt", 64'(pc_a), 64'h10);
        bjselect = 3'b110; reg_target = 32'h200;
        cyc(1);
        chk("t3.jr200", 64'(pc_a), 64'h200);
        bjselect = 3'b111;
        cyc(1);
        chk("t3.rsv", 64'(pc_a), 64'h204);
        bjselect = 3'b101;
        cyc(1);
        chk("t3.bge_nt", 64'(pc_a), 64'h208);

        bjselect = 3'b000; neg = 1'b0; ack_a = 1'b0;
        cyc(3);
        chk("t4.ack_hold", 64'(pc_a), 64'h208);
        chk("t4.ack_req", 64'(req_a), 64'h1);
        stall = 1'b1; ack_a = 1'b1;
        cyc(2);
        chk("t4.stall_hold", 64'(pc_a), 64'h208);
        chk("t4.stall_req", 64'(req_a), 64'h1);
        stall = 1'b0;
        cyc(1);
        ack_a = 1'b0;
        chk("t4.release", 64'(pc_a), 64'h20C);
        cyc(1);
        chk("t4.single", 64'(pc_a), 64'h20C);

        ack_a = 1'b1; bjselect = 3'b110; reg_target = 32'h102;
        cyc(1);
        chk("t5.trap", 64'(trap_a), 64'h1);
        chk("t5.req", 64'(req_a), 64'h0);
        chk("t5.pc", 64'(pc_a), 64'h20C);
        bjselect = 3'b000;
        cyc(3);
        chk("t5.sticky", 64'(trap_a), 64'h1);
        chk("t5.frozen", 64'(pc_a), 64'h20C);
        rst_a = 1'b0;
        #1;
        chk("t5.rst_trap", 64'(trap_a), 64'h0);
        chk("t5.rst_pc", 64'(pc_a), 64'h0);
        rst_a = 1'b1;
        cyc(1);
        chk("t5.rerun", 64'(req_a), 64'h1);

        rst_b = 1'b1;
        cyc(1);
        chk("t6.boot_pc", 64'(pc_b), 64'hFFFF_FFFC);
        cyc(1);
        chk("t6.wrap", 64'(pc_b), 64'h0);
        chk("t6.ret1", 64'(ret_b), 64'h1);
        cyc(4);
        chk("t6.sat", 64'(ret_b), 64'h3);
        chk("t6.pc", 64'(pc_b), 64'h10);
        ack_b = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        chk("t6.async_pc", 64'(pc_b), 64'hFFFF_FFFC);
        chk("t6.async_ret", 64'(ret_b), 64'h0);
        chk("t6.async_req", 64'(req_b), 64'h0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
